// File: rtl/bzmusic_pkg.sv
// Shared types and helpers for the buzzer music sequencer.
// A ROM word is {tone, dur}; the helpers slice it for any field widths up to 32 bits total.
package bzmusic_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, PLAY, GAP} state_t;

  localparam int REST_CODE = 0;
  localparam int END_DUR   = 0;

  function automatic logic [31:0] word_tone(input logic [31:0] word, input int dur_w);
    return word >> dur_w;
  endfunction

  function automatic logic [31:0] word_dur(input logic [31:0] word, input int dur_w);
    return word & ((32'd1 << dur_w) - 32'd1);
  endfunction

endpackage

// File: rtl/bzmusic_beat_cnt.sv
// Loadable beat/duration down-counter; term flags the last active cycle of a note.
module bzmusic_beat_cnt #(
  parameter int BEAT_W = 24,
  parameter int DUR_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic              run,
  input  logic [BEAT_W-1:0] beat_len,
  input  logic [DUR_W-1:0]  dur,
  output logic              term
);

  logic [BEAT_W-1:0] beat_cnt;
  logic [DUR_W-1:0]  dur_cnt;

  assign term = run && (beat_cnt == '0) && (dur_cnt == DUR_W'(1));

  // beat_len is already clamped to at least 1 by the caller
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      beat_cnt <= '0;
      dur_cnt  <= '0;
    end else if (load) begin
      beat_cnt <= beat_len - BEAT_W'(1);
      dur_cnt  <= dur;
    end else if (run) begin
      if (beat_cnt == '0) begin
        beat_cnt <= beat_len - BEAT_W'(1);
        dur_cnt  <= dur_cnt - DUR_W'(1);
      end else begin
        beat_cnt <= beat_cnt - BEAT_W'(1);
      end
    end
  end

endmodule

// File: rtl/bzmusic_seq.sv
// Buzzer music sequencer: walks the note ROM between programmable bounds and drives tone/enable.
// All outputs are registered copies of the next-state decode, so they line up with the state.
module bzmusic_seq
  import bzmusic_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TONE_W  = 6,
  parameter int DUR_W   = 4,
  parameter int BEAT_W  = 24,
  parameter int GAP_CYC = 16,
  parameter int ROM_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    pause,
  input  logic                    loop_en,
  input  logic [ADDR_W-1:0]       start_addr,
  input  logic [ADDR_W-1:0]       end_addr,
  input  logic [BEAT_W-1:0]       beat_len,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [TONE_W+DUR_W-1:0] rom_data,
  output logic [TONE_W-1:0]       tone,
  output logic                    tone_en,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W-1:0]       cur_addr
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  state_t            state, next_state;
  logic [ADDR_W-1:0] addr, addr_nxt, start_r, end_r, cur_addr_nxt;
  logic [BEAT_W-1:0] beat_r;
  logic [1:0]        fetch_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [TONE_W-1:0] cap_tone, tone_nxt;
  logic [DUR_W-1:0]  cap_dur;
  logic              capture, load, run, term, go_adv, go_end, song_done, tone_en_nxt;

  assign cap_tone = TONE_W'(word_tone(32'(rom_data), DUR_W));
  assign cap_dur  = DUR_W'(word_dur(32'(rom_data), DUR_W));
  assign capture  = (state == FETCH) && (fetch_cnt == 2'(ROM_LAT));
  assign load     = (state == FETCH) && (next_state == PLAY);
  assign run      = (state == PLAY) && !pause;

  bzmusic_beat_cnt #(.BEAT_W(BEAT_W), .DUR_W(DUR_W)) u_beat_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear    (next_state == IDLE),
    .load     (load),
    .run      (run),
    .beat_len (beat_r),
    .dur      (cap_dur),
    .term     (term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      start_r   <= '0;
      end_r     <= '0;
      beat_r    <= '0;
      fetch_cnt <= '0;
      gap_cnt   <= '0;
    end else begin
      state <= next_state;
      addr  <= addr_nxt;
      if (state == IDLE && next_state == FETCH) begin
        start_r <= start_addr;
        end_r   <= end_addr;
        beat_r  <= (beat_len == '0) ? BEAT_W'(1) : beat_len;
      end
      fetch_cnt <= (state == FETCH && next_state == FETCH && !capture) ? fetch_cnt + 2'd1 : '0;
      if (state == GAP && next_state == GAP)
        gap_cnt <= pause ? gap_cnt : gap_cnt + GAP_W'(1);
      else
        gap_cnt <= '0;
    end
  end

  // Song end and the advance step are shared by FETCH, PLAY and GAP; stop overrides everything.
  always_comb begin
    next_state = state;
    addr_nxt   = addr;
    song_done  = 1'b0;
    go_adv     = 1'b0;
    go_end     = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        next_state = FETCH;
        addr_nxt   = start_addr;
      end
      FETCH: if (capture) begin
        if (cap_dur == DUR_W'(END_DUR)) go_end = 1'b1;
        else                            next_state = PLAY;
      end
      PLAY: if (term) begin
        if (GAP_CYC == 0) go_adv = 1'b1;
        else              next_state = GAP;
      end
      GAP: if (!pause && gap_cnt == GAP_W'(GAP_CYC - 1)) go_adv = 1'b1;
      default: next_state = IDLE;
    endcase
    if (go_adv) begin
      if (addr == end_r) begin
        go_end = 1'b1;
      end else begin
        addr_nxt   = addr + ADDR_W'(1);
        next_state = FETCH;
      end
    end
    if (go_end) begin
      if (loop_en) begin
        addr_nxt   = start_r;
        next_state = FETCH;
      end else begin
        next_state = IDLE;
        song_done  = 1'b1;
      end
    end
    if (stop) begin
      next_state = IDLE;
      song_done  = 1'b0;
    end
    if (next_state == IDLE) addr_nxt = '0;
  end

  always_comb begin
    tone_nxt     = tone;
    cur_addr_nxt = cur_addr;
    tone_en_nxt  = 1'b0;
    if (next_state == IDLE) begin
      tone_nxt     = '0;
      cur_addr_nxt = '0;
    end else begin
      if (capture) tone_nxt = cap_tone;
      if (load) cur_addr_nxt = addr;
      tone_en_nxt = (next_state == PLAY) && !pause && (tone_nxt != TONE_W'(REST_CODE));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr <= '0;
      tone     <= '0;
      tone_en  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cur_addr <= '0;
    end else begin
      rom_addr <= addr_nxt;
      tone     <= tone_nxt;
      tone_en  <= tone_en_nxt;
      busy     <= (next_state != IDLE);
      done     <= song_done;
      cur_addr <= cur_addr_nxt;
    end
  end

endmodule

// File: tb/tb_bzmusic_seq.sv
// Scoreboard bench for bzmusic_seq: expected tone runs and ROM addresses are queued per song
// and a negedge monitor pops them as the DUTs produce them.
module tb_bzmusic_seq;

  localparam int AW = 8;
  localparam int TW = 6;
  localparam int DW = 4;
  localparam int BW = 24;

  logic          clk = 1'b0;
  logic          rst, start, stop, pause, loop_en;
  logic [AW-1:0] start_addr, end_addr;
  logic [BW-1:0] beat_len;
  logic [AW-1:0] rom_addr1, rom_addr2, cur_addr1, cur_addr2;
  logic [9:0]    rd1, p0, p1, rd2;
  logic [TW-1:0] tone1, tone2;
  logic          tone_en1, tone_en2, busy1, busy2, done1, done2;
  logic [9:0]    rom_mem [0:255];

  always #5 clk = ~clk;

  bzmusic_seq #(.ADDR_W(AW), .TONE_W(TW), .DUR_W(DW), .BEAT_W(BW), .GAP_CYC(2), .ROM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .loop_en(loop_en),
    .start_addr(start_addr), .end_addr(end_addr), .beat_len(beat_len),
    .rom_addr(rom_addr1), .rom_data(rd1), .tone(tone1), .tone_en(tone_en1),
    .busy(busy1), .done(done1), .cur_addr(cur_addr1));

  bzmusic_seq #(.ADDR_W(AW), .TONE_W(TW), .DUR_W(DW), .BEAT_W(BW), .GAP_CYC(0), .ROM_LAT(3)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .loop_en(loop_en),
    .start_addr(start_addr), .end_addr(end_addr), .beat_len(beat_len),
    .rom_addr(rom_addr2), .rom_data(rd2), .tone(tone2), .tone_en(tone_en2),
    .busy(busy2), .done(done2), .cur_addr(cur_addr2));

  // Synchronous ROM models: latency 1 for u_dut1, latency 3 for u_dut2
  always @(posedge clk) begin
    rd1 <= rom_mem[rom_addr1];
    p0  <= rom_mem[rom_addr2];
    p1  <= p0;
    rd2 <= p1;
  end

  typedef struct {int tone; int en; int len; int cur;} run_t;
  run_t run_q[$];
  int   addr_q1[$], addr_q2[$];
  int   tests = 0, fails = 0;
  int   d1cnt = 0, d2cnt = 0;
  bit   chk_runs = 0, chk_addr = 0, chk2 = 0;
  int   run_tone, run_en, run_len, run_cur;
  bit   prev1 = 0, prev2 = 0;
  logic [AW-1:0] last1 = '0, last2 = '0;

  function automatic logic [9:0] nw(input int t, input int d);
    return {TW'(t), DW'(d)};
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic pushRun(input int t, input int e, input int l, input int c);
    run_t r;
    r.tone = t; r.en = e; r.len = l; r.cur = c;
    run_q.push_back(r);
  endtask

  task automatic emitRun();
    run_t r;
    if (!chk_runs) return;
    if (run_q.size() == 0) begin
      tests++; fails++;
      $display("[TB] FAIL run_unexpected: got tone %0d en %0d len %0d, expected none", run_tone, run_en, run_len);
      return;
    end
    r = run_q.pop_front();
    checkOutput("run_tone", run_tone, r.tone);
    checkOutput("run_en", run_en, r.en);
    checkOutput("run_len", run_len, r.len);
    if (r.en == 1) checkOutput("run_cur_addr", run_cur, r.cur);
  endtask

  task automatic popAddr(input int which, input int act);
    int e;
    if (which == 1 && addr_q1.size() > 0) e = addr_q1.pop_front();
    else if (which == 2 && addr_q2.size() > 0) e = addr_q2.pop_front();
    else begin
      tests++; fails++;
      $display("[TB] FAIL addr%0d_unexpected: got %0d, expected none", which, act);
      return;
    end
    checkOutput(which == 1 ? "rom_addr1_seq" : "rom_addr2_seq", act, e);
  endtask

  // Monitor: compresses u_dut1 tone/tone_en into runs and tracks ROM address changes while busy
  always @(negedge clk) begin
    if (done1) begin
      checkOutput("done1_busy_fall", int'({prev1, busy1}), 2);
      d1cnt++;
    end
    if (done2) begin
      checkOutput("done2_busy_fall", int'({prev2, busy2}), 2);
      d2cnt++;
    end
    if (busy1 && (!prev1 || rom_addr1 != last1) && chk_addr) popAddr(1, int'(rom_addr1));
    if (busy2 && (!prev2 || rom_addr2 != last2) && chk_addr && chk2) popAddr(2, int'(rom_addr2));
    if (busy1) begin
      if (prev1 && int'(tone1) == run_tone && int'(tone_en1) == run_en) begin
        run_len++;
      end else begin
        if (prev1) emitRun();
        run_tone = int'(tone1);
        run_en   = int'(tone_en1);
        run_len  = 1;
        run_cur  = int'(cur_addr1);
      end
    end else if (prev1) begin
      emitRun();
    end
    prev1 = busy1;
    prev2 = busy2;
    last1 = rom_addr1;
    last2 = rom_addr2;
  end

  task automatic applyStimulus(input int sa, input int ea, input int bl, input bit le);
    start_addr = AW'(sa);
    end_addr   = AW'(ea);
    beat_len   = BW'(bl);
    loop_en    = le;
    start      = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic endTest(input string name, input int exp_d1, input int exp_d2);
    int i;
    for (i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy1 && !busy2) break;
    end
    checkOutput({name, "_idle_timeout"}, int'(busy1 | busy2), 0);
    repeat (2) @(negedge clk);
    checkOutput({name, "_runs_left"}, run_q.size(), 0);
    checkOutput({name, "_addr1_left"}, addr_q1.size(), 0);
    checkOutput({name, "_addr2_left"}, addr_q2.size(), 0);
    checkOutput({name, "_done1_count"}, d1cnt, exp_d1);
    checkOutput({name, "_done2_count"}, d2cnt, exp_d2);
    run_q.delete();
    addr_q1.delete();
    addr_q2.delete();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = '0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
    start_addr = '0; end_addr = '0; beat_len = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_busy", int'(busy1), 0);
    checkOutput("reset_tone_en", int'(tone_en1), 0);
    checkOutput("reset_rom_addr", int'(rom_addr1), 0);
    checkOutput("reset_done", int'(done1 | done2), 0);

    // Song with a rest in the middle
    rom_mem[0] = nw(5, 2); rom_mem[1] = nw(0, 1); rom_mem[2] = nw(7, 1);
    chk_runs = 1; chk_addr = 1; chk2 = 1;
    pushRun(0, 0, 2, 0); pushRun(5, 1, 8, 0); pushRun(5, 0, 4, 0);
    pushRun(0, 0, 8, 0); pushRun(7, 1, 4, 2); pushRun(7, 0, 2, 0);
    addr_q1 = '{0, 1, 2}; addr_q2 = '{0, 1, 2};
    applyStimulus(0, 2, 4, 1'b0);
    endTest("rest_song", 1, 1);

    // End-of-song marker before end_addr
    rom_mem[0] = nw(3, 1); rom_mem[1] = nw(9, 0);
    pushRun(0, 0, 2, 0); pushRun(3, 1, 2, 0); pushRun(3, 0, 4, 0);
    addr_q1 = '{0, 1}; addr_q2 = '{0, 1};
    applyStimulus(0, 5, 2, 1'b0);
    endTest("end_marker", 2, 2);

    // Loop mode then stop
    rom_mem[3] = nw(2, 1); rom_mem[4] = nw(4, 1);
    chk_runs = 0;
    addr_q1 = '{3, 4, 3, 4, 3}; addr_q2 = '{3, 4, 3, 4, 3};
    applyStimulus(3, 4, 1, 1'b1);
    repeat (22) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    checkOutput("loop_stop_busy1", int'(busy1), 0);
    checkOutput("loop_stop_busy2", int'(busy2), 0);
    checkOutput("loop_stop_tone_en", int'(tone_en1 | tone_en2), 0);
    loop_en = 1'b0;
    endTest("loop", 2, 2);

    // Pause for 10 cycles mid-note, with a start pulse that must be ignored
    rom_mem[0] = nw(6, 2);
    chk_runs = 1;
    pushRun(0, 0, 2, 0); pushRun(6, 1, 3, 0); pushRun(6, 0, 10, 0);
    pushRun(6, 1, 5, 0); pushRun(6, 0, 2, 0);
    addr_q1 = '{0}; addr_q2 = '{0};
    applyStimulus(0, 0, 4, 1'b0);
    repeat (4) @(posedge clk);
    #1 pause = 1'b1;
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1 pause = 1'b0;
    endTest("pause", 3, 3);

    // Address wrap through 255 with beat_len=0
    rom_mem[254] = nw(1, 1); rom_mem[255] = nw(2, 1); rom_mem[0] = nw(3, 1); rom_mem[1] = nw(4, 1);
    pushRun(0, 0, 2, 0); pushRun(1, 1, 1, 254); pushRun(1, 0, 4, 0);
    pushRun(2, 1, 1, 255); pushRun(2, 0, 4, 0); pushRun(3, 1, 1, 0);
    pushRun(3, 0, 4, 0); pushRun(4, 1, 1, 1); pushRun(4, 0, 2, 0);
    addr_q1 = '{254, 255, 0, 1}; addr_q2 = '{254, 255, 0, 1};
    applyStimulus(254, 1, 0, 1'b0);
    endTest("wrap", 4, 4);

    // Stop and start together mid-song
    rom_mem[0] = nw(5, 2); rom_mem[1] = nw(0, 1); rom_mem[2] = nw(7, 1);
    chk_runs = 0; chk_addr = 0; chk2 = 0;
    applyStimulus(0, 2, 4, 1'b0);
    repeat (6) @(posedge clk);
    #1 stop = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0; start = 1'b0;
    checkOutput("stop_start_busy1", int'(busy1), 0);
    checkOutput("stop_start_busy2", int'(busy2), 0);
    endTest("stop_start", 4, 4);

    // Reset in the middle of a PLAY
    rom_mem[2] = nw(7, 1);
    applyStimulus(2, 2, 4, 1'b0);
    repeat (4) @(posedge clk);
    checkOutput("pre_rst_cur_addr", int'(cur_addr1), 2);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_rom_addr", int'(rom_addr1), 0);
    checkOutput("rst_tone", int'(tone1), 0);
    checkOutput("rst_tone_en", int'(tone_en1), 0);
    checkOutput("rst_busy", int'(busy1 | busy2), 0);
    checkOutput("rst_cur_addr", int'(cur_addr1), 0);
    checkOutput("rst_done", int'(done1), 0);
    rst = 1'b0;
    endTest("reset", 4, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
